// File: rtl/prim_unpacker_if.sv
// ---------------------------------------------------------------------------
// prim_unpacker_if: word-in / beat-out valid-ready bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prim_unpacker_if #(
  parameter int InW  = 32,
  parameter int OutW = 8
);
  logic            valid_i;
  logic [InW-1:0]  data_i;
  logic [InW-1:0]  mask_i;
  logic            ready_o;
  logic            valid_o;
  logic [OutW-1:0] data_o;
  logic [OutW-1:0] mask_o;
  logic            last_o;
  logic            ready_i;
  logic            clear_i;

  modport master (
    output valid_i, data_i, mask_i, ready_i, clear_i,
    input  ready_o, valid_o, data_o, mask_o, last_o
  );

  modport slave (
    input  valid_i, data_i, mask_i, ready_i, clear_i,
    output ready_o, valid_o, data_o, mask_o, last_o
  );
endinterface

`default_nettype wire

// File: rtl/prim_unpacker.sv
// ---------------------------------------------------------------------------
// prim_unpacker: mask-aware InW->OutW serializer, skips empty slices.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prim_unpacker #(
  parameter int InW  = 32,
  parameter int OutW = 8
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  prim_unpacker_if.slave bus
);

  localparam int NumBeats = InW / OutW;
  localparam int IdxW     = $clog2(NumBeats);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [InW-1:0]  data_q, data_d;
  logic [InW-1:0]  mask_q, mask_d;

  logic [NumBeats-1:0] nz_q, nz_in;
  logic [IdxW-1:0]     next_idx, first_idx;
  logic                has_next;
  logic [OutW-1:0]     cur_data, cur_mask;
  logic                busy, last, ack_in, ack_out;

  // Descending scan: the final hit is the lowest qualifying slice.
  always_comb begin
    nz_q      = '0;
    nz_in     = '0;
    next_idx  = idx_q;
    first_idx = '0;
    has_next  = 1'b0;
    cur_data  = '0;
    cur_mask  = '0;
    for (int k = NumBeats - 1; k >= 0; k--) begin
      nz_q[k]  = |mask_q[k*OutW +: OutW];
      nz_in[k] = |bus.mask_i[k*OutW +: OutW];
      if (nz_in[k]) begin
        first_idx = IdxW'(k);
      end
      if (nz_q[k] && (IdxW'(k) > idx_q)) begin
        next_idx = IdxW'(k);
        has_next = 1'b1;
      end
      if (IdxW'(k) == idx_q) begin
        cur_data = data_q[k*OutW +: OutW];
        cur_mask = mask_q[k*OutW +: OutW];
      end
    end
  end

  assign busy    = (state_q == StSend);
  assign last    = busy & ~has_next;
  assign ack_out = busy & bus.ready_i;
  assign ack_in  = bus.valid_i & bus.ready_o;

  assign bus.ready_o = ~bus.clear_i & (~busy | (ack_out & last));
  assign bus.valid_o = busy;
  assign bus.last_o  = last;
  assign bus.data_o  = busy ? cur_data : '0;
  assign bus.mask_o  = busy ? cur_mask : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (bus.clear_i) begin
      state_d = StIdle;
      idx_d   = '0;
    end else if (ack_in) begin
      // An all-zero mask is swallowed: accepted, but nothing to send.
      data_d  = bus.data_i & bus.mask_i;
      mask_d  = bus.mask_i;
      idx_d   = first_idx;
      state_d = (|bus.mask_i) ? StSend : StIdle;
    end else if (ack_out) begin
      if (last) begin
        state_d = StIdle;
      end else begin
        idx_d = next_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prim_unpacker.sv
// ---------------------------------------------------------------------------
// tb_prim_unpacker: directed + randomized checks against a beat-list model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prim_unpacker;

  localparam int InW  = 32;
  localparam int OutW = 8;
  localparam int NB   = InW / OutW;

  typedef struct packed {
    logic [OutW-1:0] d;
    logic [OutW-1:0] m;
    logic            l;
  } beat_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  beat_t exp_q[$];

  prim_unpacker_if #(.InW(InW), .OutW(OutW)) bus ();

  prim_unpacker #(.InW(InW), .OutW(OutW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat list of one word: every non-empty slice in ascending order.
  function automatic void build(input logic [InW-1:0] d, input logic [InW-1:0] m);
    int    hi;
    beat_t b;
    hi = -1;
    for (int k = 0; k < NB; k++) if (m[k*OutW +: OutW] != 0) hi = k;
    for (int k = 0; k < NB; k++) begin
      if (m[k*OutW +: OutW] != 0) begin
        b.d = d[k*OutW +: OutW] & m[k*OutW +: OutW];
        b.m = m[k*OutW +: OutW];
        b.l = (k == hi);
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic logic [InW-1:0] rand_mask();
    logic [InW-1:0] m;
    for (int k = 0; k < NB; k++) begin
      case ($urandom_range(0, 3))
        0:       m[k*OutW +: OutW] = '0;
        1:       m[k*OutW +: OutW] = '1;
        default: m[k*OutW +: OutW] = OutW'($urandom);
      endcase
    end
    return m;
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.mask_i  = '0;
    bus.ready_i = 1'b0;
    bus.clear_i = 1'b0;
    #3;
    total++;
    if ({bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h m=%h l=%b r=%b, want v=0 d=00 m=00 l=0 r=1",
               bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL reset_release: got v=%b r=%b, want v=0 r=1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_word(input string name, input logic [InW-1:0] d, input logic [InW-1:0] m);
    beat_t b;
    int    n;
    exp_q.delete();
    build(d, m);
    n = exp_q.size();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.mask_i  = m;
    bus.ready_i = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept: got ready_o=%b, want 1", name, bus.ready_o);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      b = exp_q.pop_front();
      total++;
      if ({bus.valid_o, bus.data_o, bus.mask_o, bus.last_o} !== {1'b1, b.d, b.m, b.l}) begin
        bad++;
        $display("FAIL %s_beat%0d: got v=%b d=%h m=%h l=%b, want v=1 d=%h m=%h l=%b",
                 name, i, bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, b.d, b.m, b.l);
      end
      total++;
      if (bus.ready_o !== b.l) begin
        bad++;
        $display("FAIL %s_ready%0d: got %b, want %b", name, i, bus.ready_o, b.l);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got valid_o=%b, want 0", name, bus.valid_o);
    end
  endtask

  task automatic test_full();
    test_word("full", 32'hDDCCBBAA, 32'hFFFFFFFF);
  endtask

  task automatic test_sparse();
    test_word("sparse", 32'h11223344, 32'hFF0000F0);
  endtask

  task automatic test_empty();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hCAFEF00D;
    bus.mask_i  = '0;
    bus.ready_i = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL empty_accept: got ready_o=%b, want 1", bus.ready_o);
    end
    @(negedge clk);
    bus.data_i = 32'h04030201;
    bus.mask_i = '1;
    #1;
    total++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL empty_next: got v=%b r=%b, want v=0 r=1", bus.valid_o, bus.ready_o);
    end
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      total++;
      if ({bus.valid_o, bus.data_o} !== {1'b1, 8'(i + 1)}) begin
        bad++;
        $display("FAIL empty_follow%0d: got v=%b d=%h, want v=1 d=%h", i, bus.valid_o, bus.data_o, 8'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [InW-1:0] w;
    w = 32'hDDCCBBAA;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = w;
    bus.mask_i  = '1;
    bus.ready_i = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      total++;
      if ({bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o} !== {1'b1, 8'hAA, 8'hFF, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall%0d: got v=%b d=%h m=%h l=%b r=%b, want v=1 d=aa m=ff l=0 r=0",
                 c, bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o);
      end
    end
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      bus.ready_i = 1'b1;
      #1;
      total++;
      if ({bus.valid_o, bus.data_o, bus.last_o} !== {1'b1, w[i*OutW +: OutW], (i == NB - 1)}) begin
        bad++;
        $display("FAIL resume%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, bus.valid_o, bus.data_o, bus.last_o, w[i*OutW +: OutW], (i == NB - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [InW-1:0] w1, w2, cur;
    w1 = 32'h44332211;
    w2 = 32'h88776655;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = w1;
    bus.mask_i  = '1;
    bus.ready_i = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      cur = (w == 0) ? w1 : w2;
      for (int i = 0; i < NB; i++) begin
        @(negedge clk);
        bus.valid_i = (w == 0);
        bus.data_i  = w2;
        #1;
        total++;
        if ({bus.valid_o, bus.data_o, bus.ready_o} !== {1'b1, cur[i*OutW +: OutW], (i == NB - 1)}) begin
          bad++;
          $display("FAIL b2b_w%0d_beat%0d: got v=%b d=%h r=%b, want v=1 d=%h r=%b",
                   w, i, bus.valid_o, bus.data_o, bus.ready_o, cur[i*OutW +: OutW], (i == NB - 1));
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got valid_o=%b, want 0", bus.valid_o);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hDDCCBBAA;
    bus.mask_i  = '1;
    bus.ready_i = 1'b1;
    #1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    @(negedge clk);
    bus.clear_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h12345678;
    #1;
    total++;
    if ({bus.ready_o, bus.valid_o, bus.data_o} !== {1'b0, 1'b1, 8'hBB}) begin
      bad++;
      $display("FAIL clear_cycle: got r=%b v=%b d=%h, want r=0 v=1 d=bb", bus.ready_o, bus.valid_o, bus.data_o);
    end
    @(negedge clk);
    bus.clear_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    total++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL clear_after: got v=%b r=%b, want v=0 r=1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hDDCCBBAA;
    bus.mask_i  = '1;
    bus.ready_i = 1'b1;
    #1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: got v=%b d=%h m=%h l=%b r=%b, want v=0 d=00 m=00 l=0 r=1",
               bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, bus.ready_o);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    @(negedge clk);
    #1;
    total++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL async_release: got v=%b r=%b, want v=0 r=1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_random();
    logic  exp_ready;
    beat_t f;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.data_i  = $urandom;
      bus.mask_i  = rand_mask();
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.clear_i = ($urandom_range(0, 39) == 0);
      #1;
      exp_ready = !bus.clear_i && (exp_q.size() == 0 || (bus.ready_i && exp_q.size() == 1));
      total++;
      if (bus.ready_o !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready c=%0d: got %b, want %b", c, bus.ready_o, exp_ready);
      end
      f = (exp_q.size() != 0) ? exp_q[0] : '0;
      total++;
      if ({bus.valid_o, bus.data_o, bus.mask_o, bus.last_o} !== {exp_q.size() != 0, f.d, f.m, f.l}) begin
        bad++;
        $display("FAIL rand_beat c=%0d: got v=%b d=%h m=%h l=%b, want v=%b d=%h m=%h l=%b",
                 c, bus.valid_o, bus.data_o, bus.mask_o, bus.last_o, exp_q.size() != 0, f.d, f.m, f.l);
      end
      if (exp_q.size() != 0 && bus.ready_i) void'(exp_q.pop_front());
      if (bus.clear_i) exp_q.delete();
      if (bus.valid_i && exp_ready) build(bus.data_i, bus.mask_i);
    end
    bus.clear_i = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full();
    test_sparse();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
